// File: rtl/arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, port ids and burst default.
package arb_pkg;

  localparam int unsigned BURST_LEN_DEFAULT = 4;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_BUSY = 2'd1;
  localparam arb_state_t ST_TURN = 2'd2;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    PRG  = 2'd1,
    DATA = 2'd2,
    VID  = 2'd3
  } port_id_e;

  // Rotation order PRG -> DATA -> VID -> PRG.
  function automatic port_id_e next_port(port_id_e p);
    return (p == VID || p == NONE) ? PRG : port_id_e'(p + 2'd1);
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way winner select: first requester at or after ptr, optional absolute priority for VID.
module rr_pick3
  import arb_pkg::*;
(
  input  logic [2:0] req,
  input  port_id_e   ptr,
  input  logic       prio_en,
  output port_id_e   winner,
  output logic       valid
);

  logic [2:0] req_rr;
  port_id_e   cand;

  always_comb begin
    // Under priority the rotation only covers PRG and DATA.
    req_rr = prio_en ? {1'b0, req[1:0]} : req;
    winner = NONE;
    cand   = (ptr == NONE) ? PRG : ptr;
    for (int i = 0; i < 3; i++) begin
      if (winner == NONE && req_rr[cand - 2'd1]) begin
        winner = cand;
      end
      cand = next_port(cand);
    end
    if (prio_en && req[2]) begin
      winner = VID;
    end
    valid = (winner != NONE);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-port burst arbiter in front of the SDRAM burst engine.
// Define ARB_VIDEO_PRIORITY_EN to let the video port (p3) win every IDLE arbitration it joins.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT,
  parameter int unsigned AW        = 24
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         p1_req,
  input  logic                         p1_wren,
  input  logic [AW-1:0]                p1_address,
  input  logic [15:0]                  p1_to_mem,
  output logic                         p1_ready,
  output logic [$clog2(BURST_LEN)-1:0] p1_offset,

  input  logic                         p2_req,
  input  logic                         p2_wren,
  input  logic [AW-1:0]                p2_address,
  input  logic [15:0]                  p2_to_mem,
  output logic                         p2_ready,
  output logic [$clog2(BURST_LEN)-1:0] p2_offset,

  input  logic                         p3_req,
  input  logic                         p3_wren,
  input  logic [AW-1:0]                p3_address,
  input  logic [15:0]                  p3_to_mem,
  output logic                         p3_ready,
  output logic [$clog2(BURST_LEN)-1:0] p3_offset,

  output logic                         m_req,
  output logic                         m_wren,
  output logic [AW-1:0]                m_address,
  output logic [15:0]                  m_to_mem,
  input  logic                         m_ready,
  input  logic [$clog2(BURST_LEN)-1:0] m_offset,

  output logic [1:0]                   grant
);

  localparam int unsigned OffW = $clog2(BURST_LEN);
  localparam logic [OffW-1:0] LastWord = OffW'(BURST_LEN - 1);

`ifdef ARB_VIDEO_PRIORITY_EN
  localparam logic PrioEn = 1'b1;
`else
  localparam logic PrioEn = 1'b0;
`endif

  arb_state_t    state_q, state_d;
  port_id_e      grant_q, grant_d;
  port_id_e      ptr_q, ptr_d;
  logic [OffW-1:0] cnt_q, cnt_d;

  port_id_e      winner;
  logic          win_valid;
  logic          busy;

  rr_pick3 u_pick (
    .req     ({p3_req, p2_req, p1_req}),
    .ptr     (ptr_q),
    .prio_en (PrioEn),
    .winner  (winner),
    .valid   (win_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_BUSY;
          grant_d = winner;
          cnt_d   = '0;
          // A priority video win leaves the PRG/DATA rotation where it was.
          if (!(PrioEn && winner == VID)) begin
            ptr_d = next_port(winner);
          end
        end
      end
      ST_BUSY: begin
        if (m_ready) begin
          if (cnt_q == LastWord) begin
            state_d = ST_TURN;
            grant_d = NONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + OffW'(1);
          end
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = NONE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= NONE;
      ptr_q   <= PRG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q == ST_BUSY);
  assign m_req = busy;
  assign grant = grant_q;

  always_comb begin
    m_wren    = 1'b0;
    m_address = '0;
    m_to_mem  = '0;
    p1_ready  = 1'b0;
    p2_ready  = 1'b0;
    p3_ready  = 1'b0;
    p1_offset = '0;
    p2_offset = '0;
    p3_offset = '0;
    if (busy) begin
      unique case (grant_q)
        PRG: begin
          m_wren    = p1_wren;
          m_address = p1_address;
          m_to_mem  = p1_to_mem;
          p1_ready  = m_ready;
          p1_offset = m_offset;
        end
        DATA: begin
          m_wren    = p2_wren;
          m_address = p2_address;
          m_to_mem  = p2_to_mem;
          p2_ready  = m_ready;
          p2_offset = m_offset;
        end
        VID: begin
          m_wren    = p3_wren;
          m_address = p3_address;
          m_to_mem  = p3_to_mem;
          p3_ready  = m_ready;
          p3_offset = m_offset;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences, random run.
module tb_mem_port_arbiter;

  localparam int unsigned BL = 4;
  localparam int unsigned AW = 24;

  logic clk = 1'b0;
  logic rst;
  logic [3:1] req, wren;
  logic [AW-1:0] addr [1:3];
  logic [15:0] tm [1:3];
  logic m_ready;
  logic [1:0] m_offset;

  logic p1_ready, p2_ready, p3_ready;
  logic [1:0] p1_offset, p2_offset, p3_offset;
  logic m_req, m_wren;
  logic [AW-1:0] m_address;
  logic [15:0] m_to_mem;
  logic [1:0] grant;

  logic [3:1] rdy;
  logic [1:0] off [1:3];
  assign rdy    = {p3_ready, p2_ready, p1_ready};
  assign off[1] = p1_offset;
  assign off[2] = p2_offset;
  assign off[3] = p3_offset;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .BURST_LEN (BL),
    .AW        (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p1_req     (req[1]),
    .p1_wren    (wren[1]),
    .p1_address (addr[1]),
    .p1_to_mem  (tm[1]),
    .p1_ready   (p1_ready),
    .p1_offset  (p1_offset),
    .p2_req     (req[2]),
    .p2_wren    (wren[2]),
    .p2_address (addr[2]),
    .p2_to_mem  (tm[2]),
    .p2_ready   (p2_ready),
    .p2_offset  (p2_offset),
    .p3_req     (req[3]),
    .p3_wren    (wren[3]),
    .p3_address (addr[3]),
    .p3_to_mem  (tm[3]),
    .p3_ready   (p3_ready),
    .p3_offset  (p3_offset),
    .m_req      (m_req),
    .m_wren     (m_wren),
    .m_address  (m_address),
    .m_to_mem   (m_to_mem),
    .m_ready    (m_ready),
    .m_offset   (m_offset),
    .grant      (grant)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: who owns the engine, words delivered, gap cycle, rotation pointer.
  int md_owner = 0;
  int md_words = 0;
  int md_ptr   = 1;
  bit md_turn  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(logic [3:1] r, int ptr);
`ifdef ARB_VIDEO_PRIORITY_EN
    if (r[3]) return 3;
    r[3] = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      int p = ((ptr - 1 + k) % 3) + 1;
      if (r[p]) return p;
    end
    return 0;
  endfunction

  task automatic model_update();
    int w;
    if (rst) begin
      md_owner = 0;
      md_words = 0;
      md_turn  = 1'b0;
      md_ptr   = 1;
    end else if (md_turn) begin
      md_turn = 1'b0;
    end else if (md_owner == 0) begin
      w = model_pick(req, md_ptr);
      if (w != 0) begin
        md_owner = w;
        md_words = 0;
`ifdef ARB_VIDEO_PRIORITY_EN
        if (w != 3) md_ptr = (w % 3) + 1;
`else
        md_ptr = (w % 3) + 1;
`endif
      end
    end else if (m_ready) begin
      md_words++;
      if (md_words == BL) begin
        md_owner = 0;
        md_words = 0;
        md_turn  = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    bit busy;
    busy = (md_owner != 0);
    chk("m_req", m_req, busy);
    chk("grant", grant, md_owner);
    for (int p = 1; p <= 3; p++) begin
      chk($sformatf("p%0d_ready", p), rdy[p], busy && md_owner == p && m_ready);
      chk($sformatf("p%0d_offset", p), off[p], (md_owner == p) ? m_offset : 2'd0);
    end
    if (busy) begin
      chk("m_wren", m_wren, wren[md_owner]);
      chk("m_address", m_address, addr[md_owner]);
      chk("m_to_mem", m_to_mem, tm[md_owner]);
    end
  endtask

  // Inputs are set at a falling edge; outputs sampled 1 ns later, model stepped for the next rise.
  task automatic step();
    #1;
    check_model();
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    m_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [3:1] req;
    logic       mrdy;
    logic [1:0] moff;
    logic       exp_mreq;
    logic [1:0] exp_grant;
    logic [3:1] exp_rdy;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq[$];
    int wcnt[$];
    int exp_order[4];
    int last_g, words;
    logic [1:0] g;

    // Lone p2 read at 0x000100, stray strobe in IDLE, request dropped after first strobe.
    vecs[0] = '{3'b010, 1'b1, 2'd2, 1'b0, 2'd0, 3'b000};
    vecs[1] = '{3'b010, 1'b0, 2'd0, 1'b1, 2'd2, 3'b000};
    vecs[2] = '{3'b010, 1'b1, 2'd0, 1'b1, 2'd2, 3'b010};
    vecs[3] = '{3'b000, 1'b0, 2'd1, 1'b1, 2'd2, 3'b000};
    vecs[4] = '{3'b000, 1'b1, 2'd1, 1'b1, 2'd2, 3'b010};
    vecs[5] = '{3'b000, 1'b1, 2'd2, 1'b1, 2'd2, 3'b010};
    vecs[6] = '{3'b000, 1'b1, 2'd3, 1'b1, 2'd2, 3'b010};
    vecs[7] = '{3'b010, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000};
    vecs[8] = '{3'b010, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000};
    vecs[9] = '{3'b000, 1'b0, 2'd0, 1'b1, 2'd2, 3'b000};

    rst      = 1'b1;
    req      = '0;
    wren     = '0;
    m_ready  = 1'b0;
    m_offset = '0;
    addr[1]  = 24'h111111;
    addr[2]  = 24'h000100;
    addr[3]  = 24'h333333;
    for (int p = 1; p <= 3; p++) tm[p] = 16'(p);
    @(negedge clk);

    // Reset state, with a stray engine strobe that must go nowhere.
    m_ready = 1'b1;
    step();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      req      = vecs[i].req;
      m_ready  = vecs[i].mrdy;
      m_offset = vecs[i].moff;
      #1;
      chk($sformatf("vec%0d_m_req", i), m_req, vecs[i].exp_mreq);
      chk($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
      chk($sformatf("vec%0d_ready", i), rdy, vecs[i].exp_rdy);
      chk($sformatf("vec%0d_p2_offset", i), p2_offset,
          (vecs[i].exp_grant == 2'd2) ? vecs[i].moff : 2'd0);
      if (vecs[i].exp_grant != 2'd0) begin
        chk($sformatf("vec%0d_address", i), m_address, addr[vecs[i].exp_grant]);
      end
      step();
    end

    // All three ports requesting continuously: grant order and burst length.
    do_reset();
    req     = 3'b111;
    wren    = '0;
    m_ready = 1'b1;
    last_g  = 0;
    words   = 0;
    for (int c = 0; c < 26; c++) begin
      m_offset = 2'(words);
      #1;
      g = grant;
      if (g != 0 && last_g == 0) gseq.push_back(int'(g));
      if (rdy != 0) words++;
      if (g == 0 && last_g != 0) begin
        wcnt.push_back(words);
        words = 0;
      end
      last_g = int'(g);
      step();
    end
`ifdef ARB_VIDEO_PRIORITY_EN
    exp_order = '{3, 3, 3, 3};
`else
    exp_order = '{1, 2, 3, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_order%0d", i), (i < gseq.size()) ? gseq[i] : 0, exp_order[i]);
      chk($sformatf("rr_words%0d", i), (i < wcnt.size()) ? wcnt[i] : 0, BL);
    end

    // p1 write burst with per-offset data.
    do_reset();
    req     = 3'b001;
    wren    = 3'b001;
    m_ready = 1'b0;
    step();
    req = '0;
    for (int k = 0; k < 4; k++) begin
      m_ready  = 1'b1;
      m_offset = 2'(k);
      tm[1]    = 16'hA5A0 + 16'(k);
      #1;
      chk($sformatf("wr_data%0d", k), m_to_mem, 16'hA5A0 + 16'(k));
      chk($sformatf("wr_wren%0d", k), m_wren, 1'b1);
      chk($sformatf("wr_strobe%0d", k), p1_ready, 1'b1);
      step();
    end
    m_ready = 1'b0;
    step();

    // Reset after the second strobe of a p3 burst.
    do_reset();
    req  = 3'b100;
    wren = '0;
    step();
    req      = '0;
    m_ready  = 1'b1;
    m_offset = 2'd0;
    step();
    m_offset = 2'd1;
    step();
    m_ready = 1'b0;
    rst     = 1'b1;
    step();
    rst      = 1'b0;
    m_ready  = 1'b1;
    m_offset = 2'd2;
    #1;
    chk("rst_mid_m_req", m_req, 1'b0);
    chk("rst_mid_grant", grant, 2'd0);
    chk("rst_mid_p3_ready", p3_ready, 1'b0);
    step();
    m_offset = 2'd3;
    step();
    m_ready = 1'b0;
    step();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 199) == 0);
      req  = 3'($urandom);
      wren = 3'($urandom);
      for (int p = 1; p <= 3; p++) begin
        addr[p] = AW'($urandom);
        tm[p]   = 16'($urandom);
      end
      m_ready  = ($urandom_range(0, 2) != 0);
      m_offset = 2'($urandom);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning words per burst (power of two, 2..8).
REQ-002 SHALL have parameter AW, default 24, meaning memory address width.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports pN_req  in  1  request from port N (N=1 program cache, 2 data cache, 3 video).
REQ-006 SHALL have ports pN_wren  in  1  write burst when high, read burst when low.
REQ-007 SHALL have ports pN_address  in  AW  burst base address.
REQ-008 SHALL have ports pN_to_mem  in  16  write data for the current offset.
REQ-009 SHALL have ports pN_ready  out  1  word strobe routed to port N.
REQ-010 SHALL have ports pN_offset  out  $clog2(BURST_LEN)  word index routed to port N.
REQ-011 SHALL have ports m_req, m_wren, m_address, m_to_mem  out  1/1/AW/16  to the SDRAM burst engine.
REQ-012 SHALL have ports m_ready, m_offset  in  1/$clog2(BURST_LEN)  word strobe and index from the engine.
REQ-013 SHALL have port grant  out  2  current owner (0 none, 1..3 port).

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and TURN.
REQ-015 IDLE: when any pN_req is high, SHALL latch the winner into grant and enter BUSY on the next edge; m_req SHALL rise in the same edge.
REQ-016 BUSY: m_wren, m_address and m_to_mem SHALL combinationally mux the granted port's inputs; m_req SHALL stay high.
REQ-017 BUSY: m_ready and m_offset SHALL route combinationally to the granted port only; all other pN_ready SHALL be 0 and pN_offset 0.
REQ-018 SHALL count m_ready pulses with a word counter; the BURST_LEN-th pulse SHALL clear m_req and enter TURN on the same edge.
REQ-019 TURN SHALL last exactly one cycle with m_req low and grant 0, then return to IDLE.
REQ-020 A requester dropping pN_req mid-burst SHALL NOT abort the burst; strobes still route to it.
REQ-021 m_ready asserted in IDLE or TURN SHALL be ignored and not routed.
REQ-022 Round-robin pointer SHALL advance to the port after the winner at each grant; the winner is the first requesting port at or after the pointer.
REQ-023 Simultaneous requests SHALL be resolved in a single cycle with no extra latency.
REQ-024 Worst-case latency from pN_req to m_req for a lone requester SHALL be 1 cycle.

Reset
REQ-025 On rst the FSM SHALL go to IDLE; grant=0; m_req=0; word counter=0; RR pointer=port 1; all pN_ready=0.
REQ-026 rst mid-burst SHALL drop m_req on the next edge, and no further strobes SHALL be routed.

Configuration
REQ-027 With ARB_VIDEO_PRIORITY_EN defined, p3 SHALL win whenever it requests in IDLE; p1/p2 SHALL round-robin between themselves only.
REQ-028 Without ARB_VIDEO_PRIORITY_EN, all three ports SHALL be under pure three-way round-robin.

Structure
REQ-029 A shared package arb_pkg SHALL hold the FSM state typedef, the port-id enum (NONE, PRG, DATA, VID) and BURST_LEN default.
REQ-030 The winner-select logic SHALL be a sub-module rr_pick3 (req[2:0], ptr, prio_en -> winner, valid).
REQ-031 No sub-module other than rr_pick3 SHALL be used; the FSM, counter and muxes SHALL reside in mem_port_arbiter.

Verification
REQ-032 Lone p2 read at 0x000100 -> m_req high 1 cycle after p2_req; m_address=0x000100; 4 strobes on p2_ready with offsets 0..3; 1-cycle m_req gap; grant 2 then 0.
REQ-033 p1, p2 and p3 requesting together, macro off -> grant order 1,2,3,1; each burst 4 words; no strobe leaks to idle ports.
REQ-034 Same stimulus with ARB_VIDEO_PRIORITY_EN -> p3 first, then alternation 1,2 while p3 idle; p3 re-request preempts at next IDLE.
REQ-035 p1 write, p1_to_mem=0xA5A0+offset -> m_to_mem sequence 0xA5A0..0xA5A3; m_wren high throughout BUSY.
REQ-036 rst asserted after 2nd strobe of p3 burst -> m_req=0 and grant=0 next edge; later m_ready pulses not routed.
REQ-037 Stray m_ready in IDLE, and p2_req dropped after 1st strobe -> IDLE stray ignored; p2 still receives offsets 1..3 and burst completes.
